writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage, directly downstream of the memory stage. Registers the MEM/WB bundle,
//  selects ALU result or load data, and drives the register-file write port and the WB->EX
//  forwarding path. Services ecall through a req/ack handshake with the system-call unit, writes
//  the result to a0, and counts retired instructions.
// PARAMETERS
//  DATA_W    64  datapath width
//  RD_W      6   destination-register tag width; rf_waddr = tag[4:0]
//  CNT_W     64  retired-instruction counter width
//  ECALL_RD  10  register written with the ecall result (a0)
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high reset
//  MEMWB_ready     in   1       MEM stage presents a valid bundle this cycle
//  MEMWB_wbactive  in   1       bundle writes a register
//  MEMWB_ecall     in   1       bundle is an ecall
//  dataselect      in   1       1 = write load data, 0 = write ALU result
//  memwb_aluresult in   DATA_W  ALU result
//  memwb_loadeddata in  DATA_W  load data from dcache
//  memwb_rd        in   RD_W    destination tag
//  ecall_ack       in   1       system-call unit done; ecall_result valid this cycle
//  ecall_result    in   DATA_W  value for a0
//  rf_we           out  1       register-file write enable
//  rf_waddr        out  5       register-file write index
//  rf_wdata        out  DATA_W  register-file write data
//  WBEX_wbactive   out  1       forwarding entry valid
//  WBEX_rd         out  RD_W    forwarding tag
//  WBEX_rdval      out  DATA_W  forwarding value
//  WB_stall        out  1       WB busy; MEM stage must hold its bundle
//  ecall_req       out  1       ecall request, level, held until ack
//  retired_count   out  CNT_W   instructions retired since reset
// BEHAVIOUR
//  - Reset: state IDLE; wb_valid, rf_we, WBEX_wbactive, WB_stall, ecall_req = 0;
//    retired_count = 0; data and tag regs = 0.
//  - Capture, IDLE only: MEMWB_ready=1 loads wb_rd, wb_wbactive, wb_ecall, and
//    wb_data = dataselect ? loadeddata : aluresult; sets wb_valid=1.
//    MEMWB_ready=0 clears wb_valid (bubble).
//  - Outside IDLE: capture registers frozen; MEMWB inputs ignored.
//  - Latency: one cycle from MEMWB_ready to rf_we.
//  - Normal write, combinational from regs in IDLE: rf_we = wb_valid & wb_wbactive & ~wb_ecall
//    & (wb_rd[4:0]!=0). x0 is never written; an rd=0 bundle still retires.
//  - Forwarding: WBEX_rd = wb_rd; WBEX_rdval = wb_data;
//    WBEX_wbactive = rf_we in IDLE, and 0 in every other state.
//  - FSM: IDLE -> REQ when wb_valid & wb_ecall; REQ -> WRITE on ecall_ack, latching ecall_result;
//    WRITE -> IDLE unconditionally.
//  - ecall_req = 1 in REQ (registered state, never combinational on ack).
//  - WB_stall = 1 in REQ and WRITE, and in the IDLE cycle that detects the ecall.
//  - WRITE: rf_we=1, rf_waddr=ECALL_RD, rf_wdata=latched result, for exactly one cycle.
//  - Retire: retired_count += 1 on each normal IDLE retirement (wb_valid & ~wb_ecall) and in WRITE.
//    Wraps modulo 2^CNT_W.
//  - ecall_ack outside REQ is ignored.
//  - Reset mid-ecall: returns to IDLE; drops req; no a0 write; count cleared.
// STRUCTURE
//  - Shared pipeline package: wb_state_e {IDLE,REQ,WRITE}; REG_ZERO=0; REG_A0=10.
//  - No sub-modules. The FSM and retire counter are inline.
// TESTING
//  1 ALU op: ready=1, rd=5, alu=0x1234, dataselect=0 -> next cycle rf_we=1, waddr=5,
//    wdata=0x1234, count=1.
//  2 Load: dataselect=1, load=0xDEAD, alu=0x10, rd=7 -> wdata=0xDEAD; WBEX_rdval=0xDEAD.
//  3 rd=0, wbactive=1 -> rf_we=0; count still increments.
//  4 Ecall, ack after 3 cycles, result=0x2A -> ecall_req high 3 cycles, WB_stall high,
//    one-cycle write of x10=0x2A, then IDLE.
//  5 Reset asserted while in REQ -> ecall_req=0, no write, count=0; next bundle retires normally.
//  6 Back-to-back ready=1 for 4 bundles with one ready=0 gap -> 4 writes in order, count=4.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared pipeline definitions for the writeback stage: FSM states, register indices and default
// widths.
package writeback_stage_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WRITE} wb_state_e;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_A0   = 10;

  localparam int unsigned WB_DATA_W = 64;
  localparam int unsigned WB_RD_W   = 6;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB bundle plus the WB_stall back-pressure signal; the MEM stage is master, WB is slave.
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned RD_W   = WB_RD_W
);
  logic              MEMWB_ready;
  logic              MEMWB_wbactive;
  logic              MEMWB_ecall;
  logic              dataselect;
  logic [DATA_W-1:0] memwb_aluresult;
  logic [DATA_W-1:0] memwb_loadeddata;
  logic [RD_W-1:0]   memwb_rd;
  logic              WB_stall;

  modport master (
    output MEMWB_ready, MEMWB_wbactive, MEMWB_ecall, dataselect,
    output memwb_aluresult, memwb_loadeddata, memwb_rd,
    input  WB_stall
  );

  modport slave (
    input  MEMWB_ready, MEMWB_wbactive, MEMWB_ecall, dataselect,
    input  memwb_aluresult, memwb_loadeddata, memwb_rd,
    output WB_stall
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the MEM/WB bundle, drives the register-file write port and
// WB->EX forwarding, services ecall via a req/ack handshake, and counts retired instructions.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned RD_W     = WB_RD_W,
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned ECALL_RD = REG_A0
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  memwb,
  input  logic              ecall_ack,
  input  logic [DATA_W-1:0] ecall_result,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              WBEX_wbactive,
  output logic [RD_W-1:0]   WBEX_rd,
  output logic [DATA_W-1:0] WBEX_rdval,
  output logic              ecall_req,
  output logic [CNT_W-1:0]  retired_count
);

  wb_state_e         state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wbactive_q, wb_wbactive_d;
  logic              wb_ecall_q, wb_ecall_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] ecall_res_q, ecall_res_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic ecall_detect;
  logic normal_we;
  logic stall;

  assign ecall_detect = (state_q == IDLE) && wb_valid_q && wb_ecall_q;
  assign normal_we    = wb_valid_q && wb_wbactive_q && !wb_ecall_q &&
                        (wb_rd_q[4:0] != 5'(REG_ZERO));

  always_comb begin
    state_d       = state_q;
    wb_valid_d    = wb_valid_q;
    wb_wbactive_d = wb_wbactive_q;
    wb_ecall_d    = wb_ecall_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    ecall_res_d   = ecall_res_q;
    retired_d     = retired_q;

    rf_we         = 1'b0;
    rf_waddr      = wb_rd_q[4:0];
    rf_wdata      = wb_data_q;
    WBEX_wbactive = 1'b0;
    stall         = 1'b0;
    ecall_req     = 1'b0;

    unique case (state_q)
      IDLE: begin
        rf_we         = normal_we;
        WBEX_wbactive = normal_we;
        stall         = ecall_detect;
        if (wb_valid_q && !wb_ecall_q) retired_d = retired_q + CNT_W'(1);
        if (ecall_detect) begin
          // MEM holds its bundle while stalled, so consume the ecall and take nothing new.
          state_d    = REQ;
          wb_valid_d = 1'b0;
        end else if (memwb.MEMWB_ready) begin
          wb_valid_d    = 1'b1;
          wb_wbactive_d = memwb.MEMWB_wbactive;
          wb_ecall_d    = memwb.MEMWB_ecall;
          wb_rd_d       = memwb.memwb_rd;
          wb_data_d     = memwb.dataselect ? memwb.memwb_loadeddata : memwb.memwb_aluresult;
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      REQ: begin
        stall     = 1'b1;
        ecall_req = 1'b1;
        if (ecall_ack) begin
          ecall_res_d = ecall_result;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        rf_we     = 1'b1;
        rf_waddr  = 5'(ECALL_RD);
        rf_wdata  = ecall_res_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wb_valid_q    <= 1'b0;
      wb_wbactive_q <= 1'b0;
      wb_ecall_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      ecall_res_q   <= '0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      wb_valid_q    <= wb_valid_d;
      wb_wbactive_q <= wb_wbactive_d;
      wb_ecall_q    <= wb_ecall_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      ecall_res_q   <= ecall_res_d;
      retired_q     <= retired_d;
    end
  end

  assign memwb.WB_stall = stall;
  assign WBEX_rd        = wb_rd_q;
  assign WBEX_rdval     = wb_data_q;
  assign retired_count  = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ecall_ack;
  logic [63:0] ecall_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        WBEX_wbactive;
  logic [5:0]  WBEX_rd;
  logic [63:0] WBEX_rdval;
  logic        ecall_req;
  logic [63:0] retired_count;

  int total = 0;
  int bad   = 0;

  writeback_stage_if #(.DATA_W(64), .RD_W(6)) memwb ();

  writeback_stage #(
    .DATA_W  (64),
    .RD_W    (6),
    .CNT_W   (64),
    .ECALL_RD(10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .memwb        (memwb),
    .ecall_ack    (ecall_ack),
    .ecall_result (ecall_result),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .WBEX_wbactive(WBEX_wbactive),
    .WBEX_rd      (WBEX_rd),
    .WBEX_rdval   (WBEX_rdval),
    .ecall_req    (ecall_req),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic act, input logic ec, input logic ds,
                       input logic [63:0] alu, input logic [63:0] ld, input logic [5:0] rd);
    memwb.MEMWB_ready      = rdy;
    memwb.MEMWB_wbactive   = act;
    memwb.MEMWB_ecall      = ec;
    memwb.dataselect       = ds;
    memwb.memwb_aluresult  = alu;
    memwb.memwb_loadeddata = ld;
    memwb.memwb_rd         = rd;
  endtask

  initial begin
    reset        = 1'b1;
    ecall_ack    = 1'b0;
    ecall_result = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    tick();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_req", 64'(ecall_req), 64'd0);
    check("rst_stall", 64'(memwb.WB_stall), 64'd0);
    check("rst_fwd", 64'(WBEX_wbactive), 64'd0);
    check("rst_cnt", retired_count, 64'd0);
    check("rst_data", WBEX_rdval, 64'd0);
    reset = 1'b0;

    // 1: ALU op
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h1234, 64'h0, 6'd5);
    tick();
    check("alu_we", 64'(rf_we), 64'd1);
    check("alu_waddr", 64'(rf_waddr), 64'd5);
    check("alu_wdata", rf_wdata, 64'h1234);
    check("alu_fwd", 64'(WBEX_wbactive), 64'd1);
    check("alu_fwd_rd", 64'(WBEX_rd), 64'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("alu_cnt", retired_count, 64'd1);
    check("alu_bubble_we", 64'(rf_we), 64'd0);

    // 2: load selects loadeddata
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h10, 64'hDEAD, 6'd7);
    tick();
    check("ld_wdata", rf_wdata, 64'hDEAD);
    check("ld_fwdval", WBEX_rdval, 64'hDEAD);
    check("ld_waddr", 64'(rf_waddr), 64'd7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("ld_cnt", retired_count, 64'd2);

    // 3: rd=0 never written but retires
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h55, 64'h0, 6'd0);
    tick();
    check("x0_we", 64'(rf_we), 64'd0);
    check("x0_fwd", 64'(WBEX_wbactive), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("x0_cnt", retired_count, 64'd3);

    // 4: ecall, ack on third REQ cycle; an early ack in IDLE is ignored
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 6'd10);
    tick();
    check("ec_det_stall", 64'(memwb.WB_stall), 64'd1);
    check("ec_det_we", 64'(rf_we), 64'd0);
    check("ec_det_req", 64'(ecall_req), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    ecall_ack    = 1'b1;
    ecall_result = 64'h99;
    tick();
    check("ec_req1", 64'(ecall_req), 64'd1);
    check("ec_req1_stall", 64'(memwb.WB_stall), 64'd1);
    check("ec_req1_fwd", 64'(WBEX_wbactive), 64'd0);
    ecall_ack = 1'b0;
    tick();
    check("ec_req2", 64'(ecall_req), 64'd1);
    tick();
    check("ec_req3", 64'(ecall_req), 64'd1);
    check("ec_req3_we", 64'(rf_we), 64'd0);
    ecall_ack    = 1'b1;
    ecall_result = 64'h2A;
    tick();
    ecall_ack = 1'b0;
    check("ec_wr_we", 64'(rf_we), 64'd1);
    check("ec_wr_waddr", 64'(rf_waddr), 64'd10);
    check("ec_wr_wdata", rf_wdata, 64'h2A);
    check("ec_wr_req", 64'(ecall_req), 64'd0);
    check("ec_wr_stall", 64'(memwb.WB_stall), 64'd1);
    check("ec_wr_fwd", 64'(WBEX_wbactive), 64'd0);
    tick();
    check("ec_idle_we", 64'(rf_we), 64'd0);
    check("ec_idle_stall", 64'(memwb.WB_stall), 64'd0);
    check("ec_cnt", retired_count, 64'd4);

    // 5: reset while in REQ
    drive(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 6'd10);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("rr_req", 64'(ecall_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_req_drop", 64'(ecall_req), 64'd0);
    check("rr_we", 64'(rf_we), 64'd0);
    check("rr_cnt", retired_count, 64'd0);
    check("rr_stall", 64'(memwb.WB_stall), 64'd0);
    ecall_ack    = 1'b1;
    ecall_result = 64'h77;
    tick();
    ecall_ack = 1'b0;
    check("rr_no_write", 64'(rf_we), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h77, 64'h0, 6'd3);
    tick();
    check("rr_next_we", 64'(rf_we), 64'd1);
    check("rr_next_waddr", 64'(rf_waddr), 64'd3);
    check("rr_next_wdata", rf_wdata, 64'h77);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("rr_next_cnt", retired_count, 64'd1);

    // 6: back-to-back bundles with one gap, counted from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h11, 64'h0, 6'd1);
    tick();
    check("b2b_a_waddr", 64'(rf_waddr), 64'd1);
    check("b2b_a_wdata", rf_wdata, 64'h11);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 64'h22, 6'd2);
    tick();
    check("b2b_b_we", 64'(rf_we), 64'd1);
    check("b2b_b_wdata", rf_wdata, 64'h22);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 64'hFF, 64'h0, 6'd9);
    tick();
    check("b2b_gap_we", 64'(rf_we), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h33, 64'h0, 6'd3);
    tick();
    check("b2b_c_waddr", 64'(rf_waddr), 64'd3);
    check("b2b_c_wdata", rf_wdata, 64'h33);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h44, 64'h0, 6'd4);
    tick();
    check("b2b_d_waddr", 64'(rf_waddr), 64'd4);
    check("b2b_d_wdata", rf_wdata, 64'h44);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 6'd0);
    tick();
    check("b2b_cnt", retired_count, 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
